param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised successor to the team's 5-bit loadable up-counter.
- Adds configurable width, programmable modulus, up/down direction, wrap or saturate mode, a clock-enable prescaler, and boundary flags.
- Used as the general-purpose event, timer and modulo counter in control datapaths and timeout logic.

Parameters:
- WIDTH, 8: counter width in bits; must be at least 2.
- MAX_VAL, 2**WIDTH-1: terminal value; count range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.
- PRESCALE, 1: number of enabled clk cycles per count step; must be >= 1; 1 = step on every enabled cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous parallel load.
- data  in  WIDTH  load value.
- enable  in  1  count enable; gates the prescaler.
- up_dn  in  1  1 = count up, 0 = count down.
- count  out  WIDTH  current count, registered.
- at_max  out  1  combinational; 1 when count == MAX_VAL.
- at_zero  out  1  combinational; 1 when count == 0.
- ovf  out  1  registered one-cycle pulse on an up-step at MAX_VAL.
- unf  out  1  registered one-cycle pulse on a down-step at 0.

Behaviour:
- Reset (rst_=0, asynchronous): count=0, prescaler=0, ovf=0, unf=0. Therefore at_zero=1 and at_max=0.
- Reset release: the first edge with rst_=1 evaluates the normal priority rules below.
- Priority each edge: clear > load > enable > hold.
- clear: count=0, prescaler=0, ovf=0, unf=0.
- load:
  - count = data if data <= MAX_VAL, otherwise count = MAX_VAL (clamped).
  - prescaler=0, ovf=0, unf=0.
- enable with PRESCALE > 1:
  - Prescaler increments each enabled cycle.
  - When the prescaler equals PRESCALE-1, it returns to 0 and a "step" occurs on that edge.
  - With enable=0, the prescaler holds its value and no step occurs.
- enable with PRESCALE = 1: every enabled cycle is a step. The prescaler register is a constant 0.
- Step, up_dn=1:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL, SATURATE=0: count=0, ovf=1 next cycle.
  - count == MAX_VAL, SATURATE=1: count holds at MAX_VAL, ovf=1 next cycle (indicates an attempted overflow).
- Step, up_dn=0:
  - count > 0: count-1.
  - count == 0, SATURATE=0: count=MAX_VAL, unf=1 next cycle.
  - count == 0, SATURATE=1: count holds at 0, unf=1 next cycle.
- ovf and unf:
  - Each is high for exactly one cycle per boundary step, then returns to 0.
  - They are never high together.
  - Both are 0 on any edge without a boundary step.
- No step: count holds its value.
- up_dn is sampled only on step edges. Changing up_dn between steps has no effect on the prescaler.
- Arithmetic:
  - WIDTH-bit unsigned.
  - Comparisons against MAX_VAL are done at WIDTH bits; no intermediate wider than WIDTH+1.
  - count never leaves 0..MAX_VAL, including after a clamped load.
- Latency:
  - count updates one edge after qualifying inputs.
  - at_max and at_zero track count with no extra delay.
- Reset mid-prescale: asynchronous reset clears the prescaler immediately; counting restarts with a full PRESCALE period.
- load or clear together with enable: enable is ignored that edge, and the prescaler phase is restarted.

Test Plan (WIDTH=5, MAX_VAL=23 unless stated):
- Reset, then enable=1, up_dn=1, PRESCALE=1 for 25 cycles -> count 1..23, then 0. ovf=1 for exactly the one cycle after the 23->0 edge. at_max=1 while count=23.
- load=1, data=31 -> count=23 (clamped). Then load data=5, up_dn=0, enable for 6 cycles -> 4,3,2,1,0,23. unf pulses once after the 0->23 edge.
- SATURATE=1: load 22, count up 3 steps -> 23,23,23 with ovf pulsing on each of the last two step edges. Count down from 1 for 3 steps -> 0,0,0 with unf on the last two step edges.
- PRESCALE=3: enable for 9 cycles -> count advances 0->3, stepping on enabled cycles 3, 6 and 9. Drop enable for 2 cycles mid-period -> the step is delayed by exactly 2 cycles.
- Simultaneous clear=1, load=1, enable=1 with count=10 -> count=0 and prescaler=0. Next edge with load=1, enable=1, data=7 -> count=7, not 8.
- Assert rst_=0 asynchronously between clock edges with count=15, prescaler=1 -> count=0, ovf=unf=0 immediately. After release, the first step occurs after a full PRESCALE enabled cycles.

Source files
------------

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Purpose  : Parametrised up/down modulo counter with load, clear, prescaled
//            enable, wrap/saturate boundary handling and boundary flags.
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = 2**WIDTH - 1,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_zero,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);
   localparam int               c_PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [WIDTH-1:0] r_count;
   logic             r_ovf;
   logic             r_unf;
   logic             w_step;

   // clear and load take precedence over enable and restart the prescale phase
   generate
      if (PRESCALE > 1) begin : g_prescale
         localparam logic [c_PW-1:0] c_PLAST = c_PW'(PRESCALE - 1);
         logic [c_PW-1:0] r_presc;

         always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
               r_presc <= '0;
            end else if (clear || load) begin
               r_presc <= '0;
            end else if (enable) begin
               if (r_presc == c_PLAST) begin
                  r_presc <= '0;
               end else begin
                  r_presc <= r_presc + c_PW'(1);
               end
            end
         end

         assign w_step = enable && !clear && !load && (r_presc == c_PLAST);
      end else begin : g_noprescale
         assign w_step = enable && !clear && !load;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (load) begin
         r_count <= (data > c_MAX) ? c_MAX : data;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (w_step) begin
         if (up_dn) begin
            r_unf <= 1'b0;
            if (r_count == c_MAX) begin
               r_count <= (SATURATE != 0) ? c_MAX : '0;
               r_ovf   <= 1'b1;
            end else begin
               r_count <= r_count + WIDTH'(1);
               r_ovf   <= 1'b0;
            end
         end else begin
            r_ovf <= 1'b0;
            if (r_count == '0) begin
               r_count <= (SATURATE != 0) ? '0 : c_MAX;
               r_unf   <= 1'b1;
            end else begin
               r_count <= r_count - WIDTH'(1);
               r_unf   <= 1'b0;
            end
         end
      end else begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end
   end

   assign count   = r_count;
   assign ovf     = r_ovf;
   assign unf     = r_unf;
   assign at_max  = (r_count == c_MAX);
   assign at_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Purpose  : Scoreboard bench for param_updown_counter (WIDTH=5, MAX_VAL=23)
//            across wrap, saturate and prescale-by-3 configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

   logic       clk = 1'b0;
   logic       rst_;
   logic       clear, load, enable, up_dn;
   logic [4:0] data;

   logic [4:0] cnt0, cnt1, cnt2;
   logic [2:0] amax, azero, ovfv, unfv;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         id;
      logic [4:0] cnt;
      logic       ovf;
      logic       unf;
      string      name;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   // dut0: wrap, no prescale; dut1: saturate; dut2: wrap, prescale by 3
   param_updown_counter #(.WIDTH(5), .MAX_VAL(23), .SATURATE(0), .PRESCALE(1)) dut0 (
      .clk(clk), .rst_(rst_), .clear(clear), .load(load), .data(data),
      .enable(enable), .up_dn(up_dn), .count(cnt0), .at_max(amax[0]),
      .at_zero(azero[0]), .ovf(ovfv[0]), .unf(unfv[0]));

   param_updown_counter #(.WIDTH(5), .MAX_VAL(23), .SATURATE(1), .PRESCALE(1)) dut1 (
      .clk(clk), .rst_(rst_), .clear(clear), .load(load), .data(data),
      .enable(enable), .up_dn(up_dn), .count(cnt1), .at_max(amax[1]),
      .at_zero(azero[1]), .ovf(ovfv[1]), .unf(unfv[1]));

   param_updown_counter #(.WIDTH(5), .MAX_VAL(23), .SATURATE(0), .PRESCALE(3)) dut2 (
      .clk(clk), .rst_(rst_), .clear(clear), .load(load), .data(data),
      .enable(enable), .up_dn(up_dn), .count(cnt2), .at_max(amax[2]),
      .at_zero(azero[2]), .ovf(ovfv[2]), .unf(unfv[2]));

   task automatic chk(input string nm, input string what, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s.%s: got %0d expected %0d", nm, what, act, exp);
      end
   endtask

   task automatic check_dut(input int id, input string nm, input logic [4:0] ec,
                            input logic eo, input logic eu);
      logic [4:0] c;
      c = (id == 0) ? cnt0 : (id == 1) ? cnt1 : cnt2;
      chk(nm, "count",   int'(c),         int'(ec));
      chk(nm, "at_max",  int'(amax[id]),  (ec == 5'd23) ? 1 : 0);
      chk(nm, "at_zero", int'(azero[id]), (ec == 5'd0) ? 1 : 0);
      chk(nm, "ovf",     int'(ovfv[id]),  int'(eo));
      chk(nm, "unf",     int'(unfv[id]),  int'(eu));
   endtask

   // monitor: one expectation per driven cycle, sampled just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check_dut(e.id, e.name, e.cnt, e.ovf, e.unf);
         end
      end
   end

   task automatic drv(input logic c, input logic l, input logic [4:0] d, input logic en,
                      input logic u, input int id, input logic [4:0] ec,
                      input logic eo, input logic eu, input string nm);
      exp_t e;
      @(negedge clk);
      clear  = c;
      load   = l;
      data   = d;
      enable = en;
      up_dn  = u;
      e.id = id; e.cnt = ec; e.ovf = eo; e.unf = eu; e.name = nm;
      q.push_back(e);
   endtask

   initial begin
      rst_ = 1'b0; clear = 1'b0; load = 1'b0; data = '0; enable = 1'b0; up_dn = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) check_dut(i, "reset", 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_ = 1'b1;

      // wrap-around count up through MAX_VAL
      for (int i = 1; i <= 25; i++)
         drv(0, 0, 0, 1, 1, 0, 5'(i % 24), (i == 24), 1'b0, "up_wrap");

      // clamped load, then count down through zero
      drv(0, 1, 5'd31, 0, 0, 0, 5'd23, 0, 0, "load_clamp");
      drv(0, 1, 5'd5,  0, 0, 0, 5'd5,  0, 0, "load5");
      drv(0, 0, 0, 1, 0, 0, 5'd4,  0, 0, "dn_wrap");
      drv(0, 0, 0, 1, 0, 0, 5'd3,  0, 0, "dn_wrap");
      drv(0, 0, 0, 1, 0, 0, 5'd2,  0, 0, "dn_wrap");
      drv(0, 0, 0, 1, 0, 0, 5'd1,  0, 0, "dn_wrap");
      drv(0, 0, 0, 1, 0, 0, 5'd0,  0, 0, "dn_wrap");
      drv(0, 0, 0, 1, 0, 0, 5'd23, 0, 1, "dn_wrap");
      drv(0, 0, 0, 0, 0, 0, 5'd23, 0, 0, "dn_hold");

      // saturating configuration
      drv(0, 1, 5'd22, 0, 1, 1, 5'd22, 0, 0, "sat_load22");
      drv(0, 0, 0, 1, 1, 1, 5'd23, 0, 0, "sat_up");
      drv(0, 0, 0, 1, 1, 1, 5'd23, 1, 0, "sat_up");
      drv(0, 0, 0, 1, 1, 1, 5'd23, 1, 0, "sat_up");
      drv(0, 0, 0, 0, 1, 1, 5'd23, 0, 0, "sat_hold");
      drv(0, 1, 5'd1, 0, 0, 1, 5'd1, 0, 0, "sat_load1");
      drv(0, 0, 0, 1, 0, 1, 5'd0, 0, 0, "sat_dn");
      drv(0, 0, 0, 1, 0, 1, 5'd0, 0, 1, "sat_dn");
      drv(0, 0, 0, 1, 0, 1, 5'd0, 0, 1, "sat_dn");
      drv(0, 0, 0, 0, 0, 1, 5'd0, 0, 0, "sat_hold0");

      // prescale by 3: steps on enabled cycles 3, 6, 9
      drv(1, 0, 0, 0, 1, 2, 5'd0, 0, 0, "pre_clear");
      for (int i = 1; i <= 9; i++)
         drv(0, 0, 0, 1, 1, 2, 5'(i / 3), 0, 0, "pre_run");
      // two disabled cycles mid-period delay the step by two cycles
      drv(0, 0, 0, 1, 1, 2, 5'd3, 0, 0, "pre_gap");
      drv(0, 0, 0, 0, 1, 2, 5'd3, 0, 0, "pre_gap");
      drv(0, 0, 0, 0, 1, 2, 5'd3, 0, 0, "pre_gap");
      drv(0, 0, 0, 1, 1, 2, 5'd3, 0, 0, "pre_gap");
      drv(0, 0, 0, 1, 1, 2, 5'd4, 0, 0, "pre_gap");

      // clear beats load beats enable, and both restart the prescale phase
      drv(0, 1, 5'd10, 0, 1, 2, 5'd10, 0, 0, "pri_load10");
      drv(0, 0, 0,     1, 1, 2, 5'd10, 0, 0, "pri_phase1");
      drv(1, 1, 5'd7,  1, 1, 2, 5'd0,  0, 0, "pri_clear");
      drv(0, 1, 5'd7,  1, 1, 2, 5'd7,  0, 0, "pri_load7");
      drv(0, 0, 0,     1, 1, 2, 5'd7,  0, 0, "pri_restart");
      drv(0, 0, 0,     1, 1, 2, 5'd7,  0, 0, "pri_restart");
      drv(0, 0, 0,     1, 1, 2, 5'd8,  0, 0, "pri_restart");

      // asynchronous reset mid-prescale
      drv(0, 1, 5'd15, 0, 1, 2, 5'd15, 0, 0, "ar_load15");
      drv(0, 0, 0,     1, 1, 2, 5'd15, 0, 0, "ar_phase1");
      @(negedge clk);
      enable = 1'b0;
      load   = 1'b0;
      @(posedge clk);
      #3;
      rst_ = 1'b0;
      #1;
      check_dut(2, "async_rst", 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_ = 1'b1;
      drv(0, 0, 0, 1, 1, 2, 5'd0, 0, 0, "ar_restart");
      drv(0, 0, 0, 1, 1, 2, 5'd0, 0, 0, "ar_restart");
      drv(0, 0, 0, 1, 1, 2, 5'd1, 0, 0, "ar_restart");

      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #3;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
